// File: rtl/init_pop_pkg.sv
// Shared types and helpers for the population initialiser: seed substitute,
// FSM states, the xorshift32 step and the word-count helper.
package init_pop_pkg;

    localparam int          PRNG_W   = 32;
    localparam logic [31:0] SEED_SUB = 32'h2545F491;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_e;

    // One xorshift32 step; shifts drop overflow bits, so the result is mod 2^32.
    function automatic logic [PRNG_W-1:0] xorshift32(input logic [PRNG_W-1:0] x);
        logic [PRNG_W-1:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    function automatic int nwords(input int total);
        return (total + PRNG_W - 1) / PRNG_W;
    endfunction

endpackage

// File: rtl/xorshift32_prng.sv
// xorshift32 state register; a zero seed would lock the generator at zero,
// so it is replaced by SEED_SUB when loaded.
module xorshift32_prng
    import init_pop_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [PRNG_W-1:0] seed,
    input  logic              step,
    output logic [PRNG_W-1:0] state
);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= '0;
        end else if (load) begin
            state <= (seed == '0) ? SEED_SUB : seed;
        end else if (step) begin
            state <= xorshift32(state);
        end
    end

endmodule

// File: rtl/init_pop_gen.sv
// Fills a POP_SIZE x GENOME_W population from xorshift32, one word per cycle.
// Define INIT_POP_STREAM_EN to add a valid/ready stream of the generated words.
module init_pop_gen
    import init_pop_pkg::*;
#(
    parameter int POP_SIZE = 50,
    parameter int GENOME_W = 150,
    parameter int WORD_W   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [WORD_W-1:0]            prg_seed,
    output logic [POP_SIZE*GENOME_W-1:0] population,
    output logic                         busy,
    output logic                         done
`ifdef INIT_POP_STREAM_EN
    ,
    output logic [WORD_W-1:0]            word_out,
    output logic                         word_valid,
    input  logic                         word_ready
`endif
);

    localparam int TOTAL  = POP_SIZE * GENOME_W;
    localparam int NWORDS = nwords(TOTAL);
    localparam int LAST_W = TOTAL - WORD_W * (NWORDS - 1);
    localparam int CNT_W  = $clog2(NWORDS + 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic               r_start_d;
    logic [CNT_W-1:0]   r_cnt;
    logic [TOTAL-1:0]   r_pop;
    logic [WORD_W-1:0]  w_prng;
    logic [WORD_W-1:0]  w_next;
    logic               w_start_acc;
    logic               w_advance;
    logic               w_last;

    // Starts are only accepted outside FILL, so a mid-fill edge is simply lost.
    assign w_start_acc = start && !r_start_d && (r_state != FILL);
    assign w_next      = xorshift32(w_prng);
    assign w_last      = (r_cnt == CNT_W'(NWORDS - 1));

    xorshift32_prng u_prng (
        .clk   (clk),
        .rst   (rst),
        .load  (w_start_acc),
        .seed  (prg_seed),
        .step  (w_advance),
        .state (w_prng)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_start_d <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_d <= start;
        end
    end

    always_comb begin
        // NOTE: default assignment first keeps this block free of inferred latches.
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: if (w_start_acc) w_state_nxt = FILL;
            FILL:       if (w_advance && w_last) w_state_nxt = DONE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state == FILL);
        done      = (r_state == DONE);
`ifdef INIT_POP_STREAM_EN
        word_out   = w_next;
        word_valid = (r_state == FILL);
        w_advance  = (r_state == FILL) && word_ready;
`else
        w_advance  = (r_state == FILL);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_start_acc) begin
            r_cnt <= '0;
        end else if (w_advance) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // NOTE: the population is a plain register bank, so clearing it on reset is legal and required here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pop <= '0;
        end else if (w_advance) begin
            for (int w = 0; w < NWORDS - 1; w++) begin
                if (r_cnt == CNT_W'(w)) begin
                    r_pop[w*WORD_W +: WORD_W] <= w_next;
                end
            end
            // Final word is truncated to the bits that belong to the population.
            if (w_last) begin
                r_pop[TOTAL-1 -: LAST_W] <= w_next[LAST_W-1:0];
            end
        end
    end

    assign population = r_pop;

endmodule

// File: tb/tb_init_pop_gen.sv
// Self-checking bench for init_pop_gen: scoreboard of model words per fill.
module tb_init_pop_gen;

    localparam int          POP_SIZE = 50;
    localparam int          GENOME_W = 150;
    localparam int          TOTAL    = POP_SIZE * GENOME_W;
    localparam int          NWORDS   = (TOTAL + 31) / 32;
    localparam int          LAST_W   = TOTAL - 32 * (NWORDS - 1);
    localparam int          LIMIT    = 5000;
    localparam logic [31:0] SUB_SEED = 32'h2545F491;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [31:0]      prg_seed;
    logic [TOTAL-1:0] population;
    logic             busy;
    logic             done;
`ifdef INIT_POP_STREAM_EN
    logic [31:0]      word_out;
    logic             word_valid;
    logic             word_ready;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    init_pop_gen #(.POP_SIZE(POP_SIZE), .GENOME_W(GENOME_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .prg_seed   (prg_seed),
        .population (population),
        .busy       (busy),
        .done       (done)
`ifdef INIT_POP_STREAM_EN
        ,
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] ref_step(input logic [31:0] x);
        x = x ^ {x[18:0], 13'b0};
        x = x ^ {17'b0, x[31:17]};
        x = x ^ {x[26:0], 5'b0};
        return x;
    endfunction

    function automatic logic [31:0] tail_mask(input int k);
        return (k == NWORDS - 1) ? (32'hFFFF_FFFF >> (32 - LAST_W)) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] dut_word(input int k);
        logic [NWORDS*32-1:0] ext;
        ext            = '0;
        ext[TOTAL-1:0] = population;
        return ext[k*32 +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pushes the expected words of one fill, already masked to the population width.
    task automatic push_model(input logic [31:0] seed);
        logic [31:0] x;
        exp_q.delete();
        x = (seed == 32'd0) ? SUB_SEED : seed;
        for (int k = 0; k < NWORDS; k++) begin
            x = ref_step(x);
            exp_q.push_back(x & tail_mask(k));
        end
    endtask

    task automatic run_fill(input logic [31:0] seed, input bit hold,
                            output int edges, output int busy_cycles);
        push_model(seed);
        prg_seed = seed;
        start    = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        edges       = 0;
        busy_cycles = 0;
        while (!done && edges < LIMIT) begin
            if (busy) busy_cycles++;
            tick();
            edges++;
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b0;
        prg_seed = '0;
`ifdef INIT_POP_STREAM_EN
        word_ready = 1'b1;
`endif
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++;
        if (population !== '0) begin failures++; $display("FAIL reset_population not zero"); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int edges;
        int busy_cycles;
        logic [31:0] exp;
        push_model(32'd1);
        prg_seed = 32'd1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL basic_e0 busy=%b done=%b exp busy=1 done=0", busy, done);
        end
        busy_cycles = busy ? 1 : 0;
        tick();
        edges = 1;
        checks++;
        if (dut_word(0) !== 32'h0004_2021) begin
            failures++; $display("FAIL basic_word0 got=%h exp=00042021", dut_word(0));
        end
        while (!done && edges < LIMIT) begin
            if (busy) busy_cycles++;
            tick();
            edges++;
        end
        checks++;
        if (edges != NWORDS) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", edges, NWORDS); end
        checks++;
        if (busy_cycles != NWORDS) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", busy_cycles, NWORDS); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
        for (int k = 0; k < NWORDS; k++) begin
            exp = exp_q.pop_front();
            checks++;
            if (dut_word(k) !== exp) begin
                failures++; $display("FAIL basic_word%0d got=%h exp=%h", k, dut_word(k), exp);
            end
        end
        tick();
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL basic_done_held got=%b exp=1", done); end
    endtask

    task automatic test_repeat();
        int edges;
        int busy_cycles;
        logic [TOTAL-1:0] snap;
        logic [31:0] last_exp;
        run_fill(32'd2682981917, 1'b0, edges, busy_cycles);
        checks++;
        if (edges != NWORDS) begin failures++; $display("FAIL repeat_latency1 got=%0d exp=%0d", edges, NWORDS); end
        last_exp = exp_q[NWORDS-1];
        checks++;
        if (population[TOTAL-1:32*(NWORDS-1)] !== last_exp[LAST_W-1:0]) begin
            failures++; $display("FAIL repeat_tail got=%h exp=%h",
                                 population[TOTAL-1:32*(NWORDS-1)], last_exp[LAST_W-1:0]);
        end
        snap = population;
        rst  = 1'b1;
        tick();
        checks++;
        if (population !== '0) begin failures++; $display("FAIL repeat_reset_clear not zero"); end
        rst = 1'b0;
        tick();
        run_fill(32'd2682981917, 1'b0, edges, busy_cycles);
        checks++;
        if (edges != NWORDS) begin failures++; $display("FAIL repeat_latency2 got=%0d exp=%0d", edges, NWORDS); end
        checks++;
        if (population !== snap) begin failures++; $display("FAIL repeat_identical second run differs"); end
    endtask

    task automatic test_zero_seed();
        int edges;
        int busy_cycles;
        int mism;
        logic [TOTAL-1:0] snap;
        run_fill(32'd0, 1'b0, edges, busy_cycles);
        checks++;
        if (population === '0) begin failures++; $display("FAIL zero_seed_nonzero population all zero"); end
        mism = 0;
        for (int k = 0; k < NWORDS; k++) if (dut_word(k) !== exp_q.pop_front()) mism++;
        checks++;
        if (mism != 0) begin failures++; $display("FAIL zero_seed_words got=%0d mismatching exp=0", mism); end
        snap = population;
        run_fill(SUB_SEED, 1'b0, edges, busy_cycles);
        checks++;
        if (population !== snap) begin failures++; $display("FAIL zero_seed_equiv differs from SEED_SUB run"); end
    endtask

    task automatic test_held_start();
        int edges;
        int busy_cycles;
        int bad;
        int mism;
        run_fill(32'd7, 1'b1, edges, busy_cycles);
        checks++;
        if (edges != NWORDS) begin failures++; $display("FAIL held_latency got=%0d exp=%0d", edges, NWORDS); end
        bad = 0;
        for (int i = 0; i < 1000 - NWORDS; i++) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b1) bad++;
        end
        start = 1'b0;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL held_retrigger got=%0d bad cycles exp=0", bad); end
        mism = 0;
        for (int k = 0; k < NWORDS; k++) if (dut_word(k) !== exp_q.pop_front()) mism++;
        checks++;
        if (mism != 0) begin failures++; $display("FAIL held_words got=%0d mismatching exp=0", mism); end
    endtask

    task automatic test_mid_pulse();
        int edges;
        int mism;
        tick();
        push_model(32'hCAFE_BABE);
        prg_seed = 32'hCAFE_BABE;
        start    = 1'b1;
        tick();
        start = 1'b0;
        edges = 0;
        while (!done && edges < LIMIT) begin
            if (edges == 99) begin
                start    = 1'b1;
                prg_seed = 32'h1234_5678;
            end else begin
                start = 1'b0;
            end
            tick();
            edges++;
        end
        start = 1'b0;
        checks++;
        if (edges != NWORDS) begin failures++; $display("FAIL mid_pulse_latency got=%0d exp=%0d", edges, NWORDS); end
        mism = 0;
        for (int k = 0; k < NWORDS; k++) if (dut_word(k) !== exp_q.pop_front()) mism++;
        checks++;
        if (mism != 0) begin failures++; $display("FAIL mid_pulse_words got=%0d mismatching exp=0", mism); end
    endtask

    task automatic test_async_reset();
        int edges;
        int busy_cycles;
        logic [31:0] exp;
        push_model(32'd5);
        prg_seed = 32'd5;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (49) tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL async_rst_flags busy=%b done=%b exp 0 0", busy, done);
        end
        checks++;
        if (population !== '0) begin failures++; $display("FAIL async_rst_population not zero"); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_fill(32'd5, 1'b0, edges, busy_cycles);
        checks++;
        if (edges != NWORDS) begin failures++; $display("FAIL async_rst_latency got=%0d exp=%0d", edges, NWORDS); end
        for (int k = 0; k < NWORDS; k++) begin
            exp = exp_q.pop_front();
            checks++;
            if (dut_word(k) !== exp) begin
                failures++; $display("FAIL async_rst_word%0d got=%h exp=%h", k, dut_word(k), exp);
            end
        end
    endtask

`ifdef INIT_POP_STREAM_EN
    task automatic test_stream();
        int          edges;
        int          stalls;
        int          accepted;
        int          stable_err;
        int          mism;
        bit          prev_stalled;
        logic [31:0] prev_val;
        logic [31:0] exp;
        logic [31:0] got_q[$];
        push_model(32'd9);
        prg_seed = 32'd9;
        start    = 1'b1;
        tick();
        start        = 1'b0;
        edges        = 0;
        stalls       = 0;
        accepted     = 0;
        stable_err   = 0;
        prev_stalled = 1'b0;
        prev_val     = '0;
        while (!done && edges < LIMIT) begin
            word_ready = edges[0];
            if (word_valid) begin
                if (prev_stalled && word_out !== prev_val) stable_err++;
                if (!word_ready) begin
                    stalls++;
                    prev_stalled = 1'b1;
                    prev_val     = word_out;
                end else begin
                    exp = exp_q.pop_front();
                    checks++;
                    if ((word_out & tail_mask(accepted)) !== exp) begin
                        failures++; $display("FAIL stream_word%0d got=%h exp=%h", accepted, word_out, exp);
                    end
                    got_q.push_back(word_out & tail_mask(accepted));
                    accepted++;
                    prev_stalled = 1'b0;
                end
            end
            tick();
            edges++;
        end
        word_ready = 1'b1;
        checks++;
        if (accepted != NWORDS) begin failures++; $display("FAIL stream_count got=%0d exp=%0d", accepted, NWORDS); end
        checks++;
        if (edges != NWORDS + stalls) begin
            failures++; $display("FAIL stream_latency got=%0d exp=%0d", edges, NWORDS + stalls);
        end
        checks++;
        if (stable_err != 0) begin failures++; $display("FAIL stream_stable got=%0d changes exp=0", stable_err); end
        checks++;
        if (word_valid !== 1'b0) begin failures++; $display("FAIL stream_valid_drop got=%b exp=0", word_valid); end
        mism = 0;
        for (int k = 0; k < NWORDS; k++) if (got_q.size() == 0 || dut_word(k) !== got_q.pop_front()) mism++;
        checks++;
        if (mism != 0) begin failures++; $display("FAIL stream_vs_population got=%0d mismatching exp=0", mism); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_repeat();
        test_zero_seed();
        test_held_start();
        test_mid_pulse();
        test_async_reset();
`ifdef INIT_POP_STREAM_EN
        test_stream();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
